// File: rtl/d16_uart.sv
// d16_uart: memory-mapped 8N1 UART on the d16 single-cycle bus.
// One TX holding register plus shifter, one RX holding register.
module d16_uart #(
    parameter int CLKDIV = 868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic [15:0] i_wb_addr,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_dat,
    output logic [15:0] o_wb_dat,
    input  logic        i_rx,
    output logic        o_tx,
    output logic        o_int
);
    localparam logic [15:0] DIV_M1   = 16'(CLKDIV - 1);
    localparam logic [15:0] DIV_HALF = 16'(CLKDIV / 2);

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    tx_state_t   tx_state;
    rx_state_t   rx_state;
    logic [7:0]  tx_hold;
    logic [8:0]  tx_shift;
    logic [3:0]  tx_bits;
    logic [15:0] tx_cnt;
    logic [7:0]  rx_data;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_bits;
    logic [15:0] rx_cnt;
    logic        tx_full;
    logic        rx_valid;
    logic        rx_overrun;
    logic        frame_err;
    logic        rx_ie;
    logic        tx_ie;
    logic        rx_meta;
    logic        rx_sync;

    logic        access;
    logic        wr_data;
    logic        rd_data;
    logic        wr_ctrl;
    logic        pop;
    logic        tx_busy;
    logic        tx_end;
    logic        tx_load;
    logic        tx_accept;
    logic        tx_ready;
    logic        tx_idle;
    logic        rx_done;
    logic        rx_store;
    logic        set_overrun;
    logic        set_frame;
    logic [15:0] status;
    logic        unused;

    assign access    = i_cs & i_wb_cyc;
    assign wr_data   = access & i_wb_we & ~i_wb_addr[0];
    assign rd_data   = access & ~i_wb_we & ~i_wb_addr[0];
    assign wr_ctrl   = access & i_wb_we & i_wb_addr[0];
    assign pop       = rd_data & rx_valid;

    assign tx_busy   = (tx_state == TX_SHIFT);
    assign tx_end    = tx_busy && (tx_cnt == 16'd0) && (tx_bits == 4'd9);
    assign tx_load   = tx_full & (~tx_busy | tx_end);
    // A write on the transfer edge refills the holding register.
    assign tx_accept = wr_data & (~tx_full | tx_load);
    assign tx_ready  = ~tx_full;
    assign tx_idle   = ~tx_full & ~tx_busy;

    assign rx_done     = (rx_state == RX_STOP) && (rx_cnt == 16'd0);
    assign rx_store    = rx_done & rx_sync & (~rx_valid | pop);
    assign set_overrun = rx_done & rx_sync & rx_valid & ~pop;
    assign set_frame   = rx_done & ~rx_sync;

    assign status = {9'd0, tx_ie, rx_ie, frame_err, rx_overrun,
                     tx_idle, tx_ready, rx_valid};

    assign o_int  = (rx_valid & rx_ie) | (tx_ready & tx_ie);
    assign unused = ^{i_wb_addr[15:1], i_wb_dat[15:8]};

    // Combinational read mux, zero when not selected.
    always_comb begin
        o_wb_dat = 16'd0;
        if (i_cs) begin
            o_wb_dat = i_wb_addr[0] ? status : {8'h00, rx_data};
        end
    end

    // Bus-visible registers and flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_hold    <= 8'd0;
            tx_full    <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            rx_ie      <= 1'b0;
            tx_ie      <= 1'b0;
        end else begin
            tx_full <= (tx_full & ~tx_load) | tx_accept;
            if (tx_accept) begin
                tx_hold <= i_wb_dat[7:0];
            end
            if (rx_store) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (pop) begin
                rx_valid <= 1'b0;
            end
            rx_overrun <= (rx_overrun & ~(wr_ctrl & i_wb_dat[3]))
                        | set_overrun;
            frame_err  <= (frame_err & ~(wr_ctrl & i_wb_dat[4]))
                        | set_frame;
            if (wr_ctrl) begin
                rx_ie <= i_wb_dat[5];
                tx_ie <= i_wb_dat[6];
            end
        end
    end

    // TX machine: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state <= TX_IDLE;
            o_tx     <= 1'b1;
            tx_shift <= '1;
            tx_bits  <= 4'd0;
            tx_cnt   <= 16'd0;
        end else if (tx_load) begin
            tx_state <= TX_SHIFT;
            o_tx     <= 1'b0;
            tx_shift <= {1'b1, tx_hold};
            tx_bits  <= 4'd0;
            tx_cnt   <= DIV_M1;
        end else if (tx_busy) begin
            if (tx_cnt != 16'd0) begin
                tx_cnt <= tx_cnt - 16'd1;
            end else if (tx_bits == 4'd9) begin
                tx_state <= TX_IDLE;
                o_tx     <= 1'b1;
            end else begin
                o_tx     <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bits  <= tx_bits + 4'd1;
                tx_cnt   <= DIV_M1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous RX line.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // RX machine: mid-bit sampling with start-glitch rejection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bits  <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            unique case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= DIV_HALF;
                    end
                end
                RX_START: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else if (!rx_sync) begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= DIV_M1;
                        rx_bits  <= 3'd0;
                    end else begin
                        rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_cnt   <= DIV_M1;
                        if (rx_bits == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bits <= rx_bits + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_cnt   <= DIV_M1;
                        rx_state <= rx_sync ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_d16_uart.sv
// tb_d16_uart: scoreboard bench for d16_uart.
// Reads and TX frames are checked by monitors against a cycle-level model.
module tb_d16_uart;
    localparam int DIV   = 8;
    localparam int FRAME = 10 * DIV;

    typedef struct {
        logic [15:0] val;
        logic        irq;
        string       tag;
    } rd_t;

    typedef struct {
        logic [7:0] b;
        longint     s;
    } tx_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        cs    = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [15:0] addr  = 16'd0;
    logic [15:0] wdat  = 16'd0;
    logic        rx    = 1'b1;
    logic [15:0] rdat;
    logic        tx;
    logic        irq;

    longint cyc     = 0;
    int     rst_cnt = 0;
    int     tests   = 0;
    int     fails   = 0;

    rd_t rdq[$];
    tx_t txq[$];

    // model state
    logic       m_rxv  = 1'b0;
    logic [7:0] m_rxd  = 8'd0;
    logic       m_ovr  = 1'b0;
    logic       m_fe   = 1'b0;
    logic       m_rxie = 1'b0;
    logic       m_txie = 1'b0;
    longint     s_last = -1000;

    d16_uart #(.CLKDIV(DIV)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_cs      (cs),
        .i_wb_addr (addr),
        .i_wb_cyc  (stb),
        .i_wb_we   (we),
        .i_wb_dat  (wdat),
        .o_wb_dat  (rdat),
        .i_rx      (rx),
        .o_tx      (tx),
        .o_int     (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (rst) rst_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Status as seen during the cycle that ends at edge e.
    function automatic logic [15:0] m_status(longint e);
        logic full;
        logic busy;
        full = (s_last >= e);
        busy = (s_last <= e - 1) && (e - 1 < s_last + FRAME);
        return {9'd0, m_txie, m_rxie, m_fe, m_ovr,
                !full && !busy, !full, m_rxv};
    endfunction

    function automatic logic m_irq(longint e);
        return (m_rxv & m_rxie) | (!(s_last >= e) & m_txie);
    endfunction

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus cycle; always entered just after a rising edge.
    task automatic acc(logic c, logic w, logic a, logic [15:0] d, string tag);
        longint e;
        e    = cyc + 1;
        cs   = c;
        stb  = 1'b1;
        we   = w;
        addr = {15'($urandom), a};
        wdat = d;
        if (!w) begin
            rd_t r;
            r.tag = tag;
            r.irq = m_irq(e);
            if (!c) r.val = 16'd0;
            else if (a) r.val = m_status(e);
            else r.val = {8'h00, m_rxd};
            rdq.push_back(r);
            if (c && !a) m_rxv = 1'b0;
        end else if (c) begin
            if (!a) begin
                if (!(s_last > e)) begin
                    tx_t t;
                    t.b = d[7:0];
                    t.s = (e + 1 > s_last + FRAME) ? e + 1 : s_last + FRAME;
                    s_last = t.s;
                    txq.push_back(t);
                end
            end else begin
                m_rxie = d[5];
                m_txie = d[6];
                if (d[3]) m_ovr = 1'b0;
                if (d[4]) m_fe = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        stb = 1'b0;
        cs  = 1'b0;
        we  = 1'b0;
    endtask

    // Drive one serial frame, then settle and update the model.
    task automatic send_rx(logic [7:0] b, logic stop, int hold_low);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = f[k];
            idle(DIV);
        end
        if (hold_low > 0) begin
            rx = 1'b0;
            idle(hold_low);
        end
        rx = 1'b1;
        idle(4);
        if (stop) begin
            if (!m_rxv) begin
                m_rxv = 1'b1;
                m_rxd = b;
            end else begin
                m_ovr = 1'b1;
            end
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic wait_tx_done();
        while (cyc <= s_last + FRAME + 2) idle(1);
    endtask

    task automatic mon_rd();
        forever begin
            @(negedge clk);
            if (stb && !we) begin
                if (rdq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected: got %0h expected none", rdat);
                end else begin
                    rd_t r;
                    r = rdq.pop_front();
                    check(r.tag, {16'd0, rdat}, {16'd0, r.val});
                    check({r.tag, "_int"}, {31'd0, irq}, {31'd0, r.irq});
                end
            end
        end
    endtask

    task automatic mon_tx();
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                longint     s;
                int         r0;
                logic [9:0] f;
                logic       have;
                tx_t        t;
                s    = cyc;
                r0   = rst_cnt;
                have = (txq.size() != 0);
                if (have) t = txq.pop_front();
                repeat (DIV / 2) @(negedge clk);
                f[0] = tx;
                for (int k = 1; k < 10; k++) begin
                    repeat (DIV) @(negedge clk);
                    f[k] = tx;
                end
                if (rst_cnt == r0) begin
                    if (!have) begin
                        tests++;
                        fails++;
                        $display("FAIL tx_unexpected: got %0h expected none",
                                 f[8:1]);
                    end else begin
                        check("tx_byte", {24'd0, f[8:1]}, {24'd0, t.b});
                        check("tx_start_cycle", 32'(s), 32'(t.s));
                        check("tx_start_stop", {30'd0, f[9], f[0]}, 32'd2);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        longint     t0;
        fork
            mon_rd();
            mon_tx();
        join_none

        idle(3);
        rst = 1'b0;
        idle(2);

        acc(1, 0, 1, 16'h0, "reset_status");
        acc(1, 0, 0, 16'h0, "reset_data");

        // single TX byte, status sampled densely around the end
        acc(1, 1, 0, 16'h00A5, "");
        t0 = s_last;
        while (cyc + 1 < t0 + FRAME - 2) begin
            if ($urandom_range(0, 3) == 0) acc(1, 0, 1, 16'h0, "tx1_status");
            else idle(1);
        end
        repeat (5) acc(1, 0, 1, 16'h0, "tx1_idle_edge");

        // back-to-back, third write dropped
        acc(1, 1, 0, 16'h0011, "");
        idle(3);
        acc(1, 1, 0, 16'hFF22, "");
        acc(1, 1, 0, 16'h0033, "");
        acc(1, 0, 1, 16'h0, "b2b_status");
        wait_tx_done();

        // write on the transfer edge is accepted, next one dropped
        acc(1, 1, 0, 16'h0044, "");
        acc(1, 1, 0, 16'h0055, "");
        acc(1, 1, 0, 16'h0066, "");
        acc(1, 0, 1, 16'h0, "xfer_status");
        wait_tx_done();

        // RX receive and pop with rx_ie
        acc(1, 1, 1, 16'h0020, "");
        send_rx(8'h3C, 1'b1, 0);
        acc(1, 0, 1, 16'h0, "rx_status");
        acc(1, 0, 0, 16'h0, "rx_data");
        acc(1, 0, 1, 16'h0, "rx_popped");

        // overrun and W1C clear
        send_rx(8'h55, 1'b1, 0);
        send_rx(8'hAA, 1'b1, 0);
        acc(1, 0, 0, 16'h0, "ovr_data");
        acc(1, 0, 1, 16'h0, "ovr_status");
        acc(1, 1, 1, 16'h0008, "");
        acc(1, 0, 1, 16'h0, "ovr_cleared");

        // framing error with line held low after the stop bit
        send_rx(8'h7E, 1'b0, 3 * DIV);
        idle(12 * DIV);
        acc(1, 0, 1, 16'h0, "ferr_status");
        acc(1, 1, 1, 16'hFF90, "");
        acc(1, 0, 1, 16'h0, "ferr_cleared");

        // start glitch
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(12 * DIV);
        acc(1, 0, 1, 16'h0, "glitch_status");
        send_rx(8'h81, 1'b1, 0);
        acc(1, 0, 0, 16'h0, "after_glitch_data");

        // tx_ie interrupt follows tx_ready
        acc(1, 1, 1, 16'h0040, "");
        acc(1, 0, 1, 16'h0, "txie_status");
        acc(1, 1, 0, 16'h00C3, "");
        acc(1, 1, 0, 16'h003C, "");
        acc(1, 0, 1, 16'h0, "txie_full");
        wait_tx_done();

        // randomized mix
        for (int i = 0; i < 8; i++) begin
            acc(1, 1, 0, 16'($urandom), "");
            idle($urandom_range(0, FRAME + 4));
            acc(1, 1, 0, 16'($urandom), "");
            acc(1, 1, 1, 16'($urandom), "");
            acc(1, 0, 1, 16'h0, "rnd_status_a");
            b = 8'($urandom);
            send_rx(b, ($urandom_range(0, 3) != 0), 0);
            acc(1, 0, 1, 16'h0, "rnd_status_b");
            if ($urandom_range(0, 1) == 1) acc(1, 0, 0, 16'h0, "rnd_pop");
        end
        wait_tx_done();
        acc(1, 1, 1, 16'h0018, "");

        // reset during a TX data bit
        send_rx(8'h99, 1'b1, 0);
        acc(1, 1, 1, 16'h0060, "");
        acc(1, 1, 0, 16'h005A, "");
        t0 = s_last;
        while (cyc < t0 + DIV + 3) idle(1);
        check("pre_reset_tx", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        idle(1);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_int", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        m_rxv  = 1'b0;
        m_rxd  = 8'd0;
        m_ovr  = 1'b0;
        m_fe   = 1'b0;
        m_rxie = 1'b0;
        m_txie = 1'b0;
        s_last = -1000;
        txq.delete();
        acc(1, 0, 1, 16'h0, "midreset_status");
        acc(1, 0, 0, 16'h0, "midreset_data");
        idle(FRAME);

        // chip select low: no effect, zero read data
        acc(0, 1, 0, 16'h0077, "");
        acc(0, 1, 1, 16'h0060, "");
        send_rx(8'h42, 1'b1, 0);
        acc(0, 0, 0, 16'h0, "nocs_data");
        acc(0, 0, 1, 16'h0, "nocs_status");
        acc(1, 0, 1, 16'h0, "cs_status");
        acc(1, 0, 0, 16'h0, "cs_data");
        acc(1, 0, 1, 16'h0, "cs_popped");
        idle(2 * FRAME);

        check("txq_drained", 32'(txq.size()), 32'd0);
        check("rdq_drained", 32'(rdq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
